// File: rtl/maxnet_input_loader_if.sv
// Candidate-value stream into the Maxnet input loader.
// Valid/ready: a word moves on a rising edge where in_valid && in_ready; the master holds in_data stable while in_valid is high and unaccepted.
interface maxnet_input_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/maxnet_input_loader.sv
// Buffers N candidate values into a parallel bank, launches the Maxnet core,
// and holds the operands until the core reports done.
module maxnet_input_loader #(
    parameter int DATA_W    = 32,
    parameter int N         = 4,
    parameter int START_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    maxnet_input_loader_if.slave  stream,
    output logic [N*DATA_W-1:0]   x_bank,
    output logic                  core_start,
    input  logic                  core_done,
    output logic                  neg_seen,
    output logic                  busy,
    output logic [CNT_W-1:0]      batch_count,
    output logic [1:0]            fsm_state
);
    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] BUSY   = 2'd2;

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SC_W  = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
    localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_LEN - 1);

    logic [1:0]                  state;
    logic [IDX_W-1:0]            idx;
    logic [SC_W-1:0]             start_cnt;
    logic [N-1:0][DATA_W-1:0]    bank;
    logic                        take;
    logic                        is_neg;

    // Ready is held low while reset is asserted, not just once state settles.
    assign stream.in_ready = (state == FILL) && !rst;
    assign take            = stream.in_valid && (state == FILL);
    assign is_neg          = stream.in_data[DATA_W-1];
    assign x_bank          = bank;
    assign fsm_state       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            start_cnt   <= '0;
            bank        <= '0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            neg_seen    <= 1'b0;
            batch_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (take) begin
                        // Any set sign bit, including -0.0, clamps to +0.0.
                        bank[idx] <= is_neg ? '0 : stream.in_data;
                        if (is_neg) neg_seen <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            state      <= LAUNCH;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            start_cnt  <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    if (start_cnt == START_LAST) begin
                        core_start <= 1'b0;
                        state      <= BUSY;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        batch_count <= batch_count + 1'b1;
                        busy        <= 1'b0;
                        neg_seen    <= 1'b0;
                        state       <= FILL;
                    end
                end
                default: begin
                    state      <= FILL;
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_input_loader.sv
// Directed and randomized batches against a word-level model of the loader;
// a second instance with a long start pulse covers done-during-launch.
module tb_maxnet_input_loader;
    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int CNT_W  = 16;
    localparam int LONG   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxnet_input_loader_if #(.DATA_W(DATA_W)) s_if ();
    maxnet_input_loader_if #(.DATA_W(DATA_W)) l_if ();

    logic [N*DATA_W-1:0] x_bank, l_bank;
    logic                core_start, core_done, neg_seen, busy;
    logic                l_start, l_done, l_neg, l_busy;
    logic [CNT_W-1:0]    batch_count, l_count;
    logic [1:0]          fsm_state, l_state;

    maxnet_input_loader #(.DATA_W(DATA_W), .N(N), .START_LEN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stream(s_if), .x_bank(x_bank), .core_start(core_start),
        .core_done(core_done), .neg_seen(neg_seen), .busy(busy),
        .batch_count(batch_count), .fsm_state(fsm_state)
    );

    maxnet_input_loader #(.DATA_W(DATA_W), .N(N), .START_LEN(LONG), .CNT_W(CNT_W)) dut_long (
        .clk(clk), .rst(rst), .stream(l_if), .x_bank(l_bank), .core_start(l_start),
        .core_done(l_done), .neg_seen(l_neg), .busy(l_busy),
        .batch_count(l_count), .fsm_state(l_state)
    );

    int errors = 0;
    int checks = 0;

    // Word-level model: bank contents, next slot, sticky negative flag, batches done.
    logic [DATA_W-1:0] mbank [N];
    int                midx;
    logic              mneg;
    logic [CNT_W-1:0]  mcount;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DATA_W-1:0] model_flat();
        logic [N*DATA_W-1:0] f;
        for (int i = 0; i < N; i++) f[i*DATA_W +: DATA_W] = mbank[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mbank[i] = '0;
        midx   = 0;
        mneg   = 1'b0;
        mcount = '0;
    endtask

    task automatic model_accept(input logic [DATA_W-1:0] d);
        mbank[midx] = d[DATA_W-1] ? '0 : d;
        if (d[DATA_W-1]) mneg = 1'b1;
        midx = (midx + 1) % N;
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic st, input logic bsy);
        chk({tag, ".in_ready"}, s_if.in_ready, rdy);
        chk({tag, ".core_start"}, core_start, st);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".neg_seen"}, neg_seen, mneg);
        chk({tag, ".batch_count"}, batch_count, mcount);
        chk({tag, ".x_bank"}, x_bank, model_flat());
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        @(negedge clk);
        s_if.in_data  = d;
        s_if.in_valid = 1'b1;
        check_outs("fill", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        model_accept(d);
    endtask

    task automatic gap(input logic [DATA_W-1:0] d);
        @(negedge clk);
        s_if.in_data  = d;
        s_if.in_valid = 1'b0;
        check_outs("gap", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
    endtask

    // Called right after the N-th accepted word; waits wait_cycles in BUSY before done.
    task automatic finish_batch(input int wait_cycles);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check_outs("launch", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            check_outs("busy_wait", 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        core_done = 1'b1;
        check_outs("busy_done", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        mcount = mcount + 1'b1;
        mneg   = 1'b0;
        @(negedge clk);
        core_done = 1'b0;
        check_outs("after_done", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_if.in_valid = 1'b0;
        l_if.in_valid = 1'b0;
        core_done = 1'b0;
        l_done = 1'b0;
        #1;
        model_reset();
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.long_start", l_start, 1'b0);
        chk("reset.long_busy", l_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("post_reset", 1'b1, 1'b0, 1'b0);
    endtask

    logic [DATA_W-1:0] words [N];
    logic [DATA_W-1:0] d;

    initial begin
        s_if.in_data = '0; s_if.in_valid = 1'b0;
        l_if.in_data = '0; l_if.in_valid = 1'b0;
        core_done = 1'b0; l_done = 1'b0;
        model_reset();

        // Reset values, then a plain ascending batch with done 7 cycles into BUSY.
        do_reset();
        words = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        for (int i = 0; i < N; i++) send(words[i]);
        finish_batch(7);
        chk("batch1.count", batch_count, 16'd1);

        // Second batch with random non-negative words.
        for (int i = 0; i < N; i++) send($urandom() & 32'h7FFF_FFFF);
        finish_batch($urandom_range(0, 4));
        chk("batch2.count", batch_count, 16'd2);

        // Negative and -0.0 inputs are clamped and flagged.
        words = '{32'hBF800000, 32'h3F000000, 32'h80000000, 32'h3E800000};
        for (int i = 0; i < N; i++) send(words[i]);
        chk("neg.elem0", x_bank[31:0], 32'h0);
        chk("neg.elem2", x_bank[95:64], 32'h0);
        finish_batch(2);

        // Alternating in_valid with data held: only valid cycles transfer.
        for (int i = 0; i < N; i++) begin
            d = $urandom();
            send(d);
            if (i < N - 1) gap(d);
        end
        finish_batch(1);

        // Random words (either sign) with random garbage gaps and done delays.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) gap($urandom());
                send($urandom());
            end
            finish_batch($urandom_range(0, 5));
        end

        // Reset after two accepted words, then again while busy.
        send($urandom());
        send($urandom());
        do_reset();
        for (int i = 0; i < N; i++) send($urandom());
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check_outs("launch_pre_reset", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_outs("busy_pre_reset", 1'b0, 1'b0, 1'b1);
        do_reset();
        words = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        for (int i = 0; i < N; i++) send(words[i]);
        finish_batch(7);

        // Long start pulse: done during launch is ignored.
        words = '{32'h41200000, 32'hC1200000, 32'h7F800000, 32'h7FC00000};
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            l_if.in_data  = words[i];
            l_if.in_valid = 1'b1;
            chk("long.fill_ready", l_if.in_ready, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        l_if.in_valid = 1'b0;
        for (int i = 0; i < LONG; i++) begin
            if (i > 0) @(negedge clk);
            l_done = (i == 4);
            chk("long.start", l_start, 1'b1);
            chk("long.busy", l_busy, 1'b1);
            chk("long.ready", l_if.in_ready, 1'b0);
        end
        @(negedge clk);
        l_done = 1'b0;
        chk("long.start_end", l_start, 1'b0);
        chk("long.busy_hold", l_busy, 1'b1);
        chk("long.count_ignored", l_count, 16'd0);
        chk("long.neg", l_neg, 1'b1);
        chk("long.bank", l_bank, {32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h41200000});
        @(negedge clk);
        l_done = 1'b1;
        @(negedge clk);
        l_done = 1'b0;
        chk("long.count", l_count, 16'd1);
        chk("long.busy_end", l_busy, 1'b0);
        chk("long.neg_clear", l_neg, 1'b0);
        chk("long.ready_end", l_if.in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
